// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one memory-side cache bus between NUM_REQ masters.
// The grant is held for a whole transaction and released only on iresp ready && last.
module cbus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ),
    // Request layout (MSB first): valid, is_write, addr[31:0], data[31:0], strobe[3:0], len[3:0]
    parameter int REQ_W   = 74,
    // Response layout (MSB first): ready, last, data[31:0]
    parameter int RESP_W  = 34
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ*REQ_W-1:0]  ireqs,
    output logic [NUM_REQ*RESP_W-1:0] oresps,
    output logic [REQ_W-1:0]          oreq,
    input  logic [RESP_W-1:0]         iresp,
    output logic                      dbg_busy,
    output logic [IDX_W-1:0]          dbg_grant
);

    // Handshake: a master holds its request (valid and all fields) stable until it
    // sees ready && last on its own response; ready alone marks one accepted beat.
    localparam int REQ_VALID  = REQ_W - 1;
    localparam int RESP_READY = RESP_W - 1;
    localparam int RESP_LAST  = RESP_W - 2;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             found;
    int               scan_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        oreq         = '0;
        oresps       = '0;
        found        = 1'b0;
        scan_idx     = 0;
        case (state_q)
            IDLE: begin
                // Scan starts just after the previous winner so every master gets a turn.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    scan_idx = (int'(last_grant_q) + k) % NUM_REQ;
                    if (!found && ireqs[scan_idx*REQ_W + REQ_VALID]) begin
                        found   = 1'b1;
                        grant_d = IDX_W'(scan_idx);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                oreq = ireqs[int'(grant_q)*REQ_W +: REQ_W];
                oresps[int'(grant_q)*RESP_W +: RESP_W] = iresp;
                if (iresp[RESP_READY] && iresp[RESP_LAST]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_busy  = (state_q == BUSY);
    assign dbg_grant = grant_q;

endmodule
